// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per transaction over valid/ready,
// fixed access latency, byte/halfword/word little-endian access with error flagging.
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// BUSY  | latency countdown on a captured request
// RESP  | response held on rsp_* until rsp_ready
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int       AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    // With LATENCY=1 the commit edge is the accept edge, so decode from the live inputs.
    logic        in_idle;
    logic        eff_we;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [2:0]  eff_f3;
    logic        commit;

    assign in_idle   = (state_q == IDLE);
    assign eff_we    = in_idle ? req_we     : we_q;
    assign eff_addr  = in_idle ? req_addr   : addr_q;
    assign eff_wdata = in_idle ? req_wdata  : wdata_q;
    assign eff_f3    = in_idle ? req_funct3 : f3_q;

    assign commit = reset &&
                    ((in_idle && req_valid && (LATENCY == 1)) ||
                     (state_q == BUSY && cnt_q == 4'd1));

    logic [AW-1:0] mem_idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic          f3_ok;
    logic          misal;
    logic          oor;
    logic          acc_err;
    logic [31:0]   ld_ext;
    logic [31:0]   ld_data;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          mem_we;

    assign mem_idx = eff_addr[AW+1:2];
    assign rd_word = mem[mem_idx];
    assign rd_byte = rd_word[{eff_addr[1:0], 3'b000} +: 8];
    assign rd_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        f3_ok = 1'b0;
        if (eff_we) begin
            f3_ok = (eff_f3 == 3'b000) || (eff_f3 == 3'b001) || (eff_f3 == 3'b010);
        end else begin
            f3_ok = (eff_f3 == 3'b000) || (eff_f3 == 3'b001) || (eff_f3 == 3'b010) ||
                    (eff_f3 == 3'b100) || (eff_f3 == 3'b101);
        end
        misal   = ((eff_f3[1:0] == 2'b01) && eff_addr[0]) ||
                  ((eff_f3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
        oor     = ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));
        acc_err = !f3_ok || misal || oor;
    end

    always_comb begin
        ld_ext = 32'd0;
        case (eff_f3)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_ext = rd_word;
            3'b100:  ld_ext = {24'd0, rd_byte};
            3'b101:  ld_ext = {16'd0, rd_half};
            default: ld_ext = 32'd0;
        endcase
        ld_data = (eff_we || acc_err) ? 32'd0 : ld_ext;
    end

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = eff_wdata;
        case (eff_f3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << eff_addr[1:0];
                wr_data = {4{eff_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = eff_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{eff_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = eff_wdata;
            end
        endcase
        mem_we = commit && eff_we && !acc_err;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && wr_be[i]) begin
                mem[mem_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            f3_q        <= 3'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        f3_q        <= req_funct3;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= ld_data;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= LAT_M1;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ld_data;
                        rsp_err_q   <= acc_err;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the core's load/store interface.
- Accepts one load or store request per transaction through a valid/ready handshake, waits a configurable access latency, then returns a response that is held until consumed.
- Handles byte, halfword and word accesses in little-endian order, with sign or zero extension on loads.
- Flags misaligned, out-of-range and illegal-funct3 accesses.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage. Word index is req_addr[31:2].
- LATENCY, 2: cycles from the accept edge to the first cycle rsp_valid is high. Legal range is 1 to 15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data. The low byte or halfword is used for narrow stores.
- req_funct3  input  3  access size and signedness, RV32I encoding.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access was rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latency counter is cleared.
  - Memory array contents are not reset.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 the request is captured (we, addr, wdata, funct3) at the clock edge.
  - Next state is RESP if LATENCY=1, otherwise BUSY with counter=LATENCY-1.
- BUSY:
  - req_ready=0.
  - Counter decrements each cycle.
  - Goes to RESP on the edge where counter==1.
- Commit edge (the edge entering RESP):
  - A legal store writes memory here.
  - A legal load samples memory here.
  - rsp_valid, rsp_rdata and rsp_err are registered here.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable.
  - req_ready=0.
  - On rsp_ready=1, goes to IDLE at the next edge. rsp_valid=0 and rsp_rdata/rsp_err clear to 0.
  - No same-cycle re-accept; the minimum transaction period is LATENCY+1 cycles.
- Timing: request accepted at edge t gives rsp_valid high from cycle t+LATENCY.
- Loads, selected by funct3 (byte lane = addr[1:0], halfword lane = addr[1]):
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended halfword.
- Stores, selected by funct3. Only the addressed byte lanes are written; other lanes are unchanged.
  - 000 SB: wdata[7:0].
  - 001 SH: wdata[15:0].
  - 010 SW: full word.
- Error conditions (rsp_err=1):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
  - funct3 not listed above for the given direction. This includes 011/110/111 for loads, and anything other than 000/001/010 for stores.
  - On error: no memory write occurs and rsp_rdata=0. The full latency and handshake are still observed.
- Request inputs are ignored outside IDLE. Changes to them while BUSY or RESP have no effect.
- rsp_ready is ignored outside RESP.
- Reset asserted during BUSY: the captured request is discarded and no write occurs.
- Reset asserted during RESP: the response is dropped. A store that already committed remains in memory.
- A load immediately following a store to the same address returns the stored data.

Test Plan:
- LATENCY=2. SW addr 0x10 data 0xDEADBEEF accepted at edge t, rsp_ready=1 → rsp_valid high in cycle t+2 only, rsp_err=0, rsp_rdata=0. Then LW 0x10 → rsp_rdata=0xDEADBEEF.
- After the word above: LB 0x13 → 0xFFFFFFDE. LBU 0x13 → 0x000000DE. LH 0x12 → 0xFFFFDEAD. LHU 0x10 → 0x0000BEEF.
- SB 0x11 data 0x00000055, then LW 0x10 → 0xDEAD55EF. SH 0x12 data 0x1234, then LW 0x10 → 0x123455EF.
- LW 0x11 → rsp_err=1, rsp_rdata=0. SH 0x13 → rsp_err=1 and memory unchanged. LW at byte address 4*DEPTH_WORDS → rsp_err=1. Load with funct3=011 → rsp_err=1.
- Response backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0, and a new req_valid is ignored. Then rsp_ready=1 for 1 cycle → IDLE and req_ready=1 the next cycle.
- Drive reset=0 mid-BUSY during SW 0x20 data 0x11111111 (location previously 0) → outputs go to reset values immediately (asynchronously). After release, LW 0x20 → 0x00000000. Repeat with LATENCY=1 → rsp_valid at t+1.
